// File: rtl/core_pkg.sv
// Shared core types used by the execute-side units.
// Holds the uop and branch broadcast bundles.
package core_pkg;

    localparam int SQN_WIDTH = 7;

    typedef logic [SQN_WIDTH-1:0] SqN;

    typedef struct packed {
        logic [31:0] srcA;
        logic [31:0] srcB;
        logic [6:0]  tagDst;
        logic [4:0]  opcode;
        SqN          sqN;
        logic        valid;
    } EX_UOp;

    typedef struct packed {
        SqN   sqN;
        logic taken;
    } BranchProv;

endpackage

// File: rtl/fpu_issue_arbiter_pkg.sv
// FPU issue arbiter: defaults and sqN age helpers.
// Age compares use the wrapped signed difference of sqNs.
package fpu_issue_arbiter_pkg;
    import core_pkg::*;

    localparam int DEF_NUM_PORTS = 2;
    localparam int DEF_SQN_W     = SQN_WIDTH;

    // True when sqN is younger than the taken branch.
    function automatic logic isFlushed(input SqN sqN, input BranchProv br);
        SqN d;
        d = sqN - br.sqN;
        return br.taken && !d[SQN_WIDTH-1] && (d != '0);
    endfunction

    // True when a is strictly older than b.
    function automatic logic isOlder(input SqN a, input SqN b);
        SqN d;
        d = a - b;
        return d[SQN_WIDTH-1];
    endfunction

endpackage

// File: rtl/fpu_issue_arbiter_if.sv
// FPU issue arbiter bus: issue requests in, FPU uop out.
// master = issue side / FPU, slave = arbiter.
interface fpu_issue_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    import core_pkg::*;

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                 en;
    BranchProv            IN_branch;
    EX_UOp                IN_uop [NUM_PORTS];
    logic [NUM_PORTS-1:0] OUT_stall;
    EX_UOp                OUT_uop;
    logic                 OUT_fpuEn;
    logic [PW-1:0]        OUT_grantPort;

    modport master (
        output en, IN_branch, IN_uop,
        input  OUT_stall, OUT_uop, OUT_fpuEn, OUT_grantPort
    );

    modport slave (
        input  en, IN_branch, IN_uop,
        output OUT_stall, OUT_uop, OUT_fpuEn, OUT_grantPort
    );

endinterface

// File: rtl/fpu_issue_arbiter_slot.sv
// One-entry holding slot for a single FPU issue port.
// A granted slot may reload in the same cycle.
module fpu_arb_slot
    import core_pkg::*;
    import fpu_issue_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  EX_UOp     inUop,
    input  BranchProv branch,
    input  logic      grant,
    output logic      full,
    output logic      cand,
    output EX_UOp     uop,
    output logic      stall
);

    logic heldFlush;
    logic inFlush;
    logic accept;

    // Candidate, backpressure and accept decisions.
    always_comb begin
        heldFlush = full && isFlushed(uop.sqN, branch);
        inFlush   = isFlushed(inUop.sqN, branch);
        cand      = full && !heldFlush;
        stall     = cand && !grant;
        accept    = inUop.valid && !stall && !inFlush;
    end

    // Occupancy: reload wins over drain so nothing upstream is lost.
    always_ff @(posedge clk) begin
        if (rst)
            full <= 1'b0;
        else if (accept)
            full <= 1'b1;
        else if (heldFlush || grant)
            full <= 1'b0;
    end

    // Payload capture.
    always_ff @(posedge clk) begin
        if (accept)
            uop <= inUop;
    end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares the single-cycle FPU between issue ports (oldest-first).
// FPU_ARB_ROUND_ROBIN_EN selects round-robin instead of age.
module fpu_issue_arbiter
    import core_pkg::*;
    import fpu_issue_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int SQN_W     = DEF_SQN_W
)(
    input logic                clk,
    input logic                rst,
    fpu_issue_arbiter_if.slave bus
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] stall;
    EX_UOp                slotUop [NUM_PORTS];

    logic [PW-1:0]        win;
    logic                 anyCand;
    EX_UOp                nxtUop;
    EX_UOp                outUop;
    logic [PW-1:0]        grantPort;
    logic [SQN_W-1:0]     outSqN;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : gSlot
        fpu_arb_slot uSlot (
            .clk    (clk),
            .rst    (rst),
            .inUop  (bus.IN_uop[g]),
            .branch (bus.IN_branch),
            .grant  (grant[g]),
            .full   (full[g]),
            .cand   (cand[g]),
            .uop    (slotUop[g]),
            .stall  (stall[g])
        );
    end

`ifdef FPU_ARB_ROUND_ROBIN_EN
    logic [PW-1:0] rrPtr;
    logic [PW:0]   rrSum;
    logic [PW-1:0] rrIdx;

    // Round-robin pick: first candidate at or after rrPtr.
    always_comb begin
        win     = '0;
        anyCand = 1'b0;
        rrSum   = '0;
        rrIdx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            rrSum = {1'b0, rrPtr} + (PW+1)'(k);
            if (rrSum >= (PW+1)'(NUM_PORTS))
                rrSum = rrSum - (PW+1)'(NUM_PORTS);
            rrIdx = rrSum[PW-1:0];
            if (cand[rrIdx]) begin
                win     = rrIdx;
                anyCand = 1'b1;
            end
        end
    end

    // Pointer moves past the winner on every grant.
    always_ff @(posedge clk) begin
        if (rst)
            rrPtr <= '0;
        else if (|grant)
            rrPtr <= (win == PW'(NUM_PORTS - 1)) ? '0 : win + PW'(1);
    end
`else
    // Age pick: oldest candidate, lowest index on a tie.
    always_comb begin
        win     = '0;
        anyCand = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (cand[i] &&
                (!anyCand || isOlder(slotUop[i].sqN, slotUop[win].sqN))) begin
                win     = PW'(i);
                anyCand = 1'b1;
            end
        end
    end
`endif

    // Grant vector and next FPU uop.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            grant[i] = bus.en && anyCand && (win == PW'(i));
        nxtUop       = slotUop[win];
        nxtUop.valid = 1'b1;
    end

    // FPU input register.
    always_ff @(posedge clk) begin
        if (rst) begin
            outUop.valid <= 1'b0;
            grantPort    <= '0;
        end else if (|grant) begin
            outUop    <= nxtUop;
            grantPort <= win;
        end else begin
            outUop.valid <= 1'b0;
        end
    end

    assign outSqN            = outUop.sqN;
    assign bus.OUT_stall     = stall;
    assign bus.OUT_uop       = outUop;
    assign bus.OUT_grantPort = grantPort;
    assign bus.OUT_fpuEn     = bus.en && outUop.valid &&
                               !isFlushed(outSqN, bus.IN_branch);

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Scoreboard bench for fpu_issue_arbiter.
// Reference model tracks slots per port and predicts each issue.
module tb_fpu_issue_arbiter;
    import core_pkg::*;

    localparam int NP   = 2;
    localparam int MASK = (1 << SQN_WIDTH) - 1;

    typedef struct {
        int    cyc;
        EX_UOp u;
        int    port;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_issue_arbiter_if #(.NUM_PORTS(NP)) bus();

    fpu_issue_arbiter #(.NUM_PORTS(NP), .SQN_W(SQN_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    seq   = 1;
    int    mRr   = 0;
    bit    monOn = 0;
    bit    mFull [NP];
    EX_UOp mUop  [NP];
    EX_UOp pend  [NP];
    exp_t  q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit younger(input int a, input int b);
        int d;
        d = (a - b) & MASK;
        return (d != 0) && (d < (MASK + 1) / 2);
    endfunction

    function automatic bit fl(input EX_UOp u);
        return bus.IN_branch.taken &&
               younger(int'(u.sqN), int'(bus.IN_branch.sqN));
    endfunction

    function automatic EX_UOp mk(input int s);
        EX_UOp u;
        u        = '0;
        u.valid  = 1'b1;
        u.sqN    = SqN'(s & MASK);
        u.srcA   = $urandom;
        u.srcB   = $urandom;
        u.tagDst = 7'($urandom);
        u.opcode = 5'($urandom);
        return u;
    endfunction

    // One clock: drive, predict, check stalls, advance the model.
    task automatic step(input bit doRst);
        bit cand [NP];
        bit st, acc, best;
        int win, p;
        rst = doRst;
        if (doRst)
            for (int i = 0; i < NP; i++) pend[i] = '0;
        for (int i = 0; i < NP; i++) bus.IN_uop[i] = pend[i];
        @(negedge clk);
        for (int i = 0; i < NP; i++) cand[i] = mFull[i] && !fl(mUop[i]);
        win = -1;
        if (bus.en) begin
`ifdef FPU_ARB_ROUND_ROBIN_EN
            for (int k = 0; k < NP; k++) begin
                p = (mRr + k) % NP;
                if (cand[p] && win < 0) win = p;
            end
`else
            for (int i = 0; i < NP; i++) begin
                best = cand[i];
                for (int j = 0; j < NP; j++)
                    if (j != i && cand[j] &&
                        younger(int'(mUop[i].sqN), int'(mUop[j].sqN)))
                        best = 0;
                if (best) win = i;
            end
`endif
        end
        if (!doRst && win >= 0) q.push_back('{cyc + 1, mUop[win], win});
        for (int i = 0; i < NP; i++) begin
            st = cand[i] && (win != i);
            if (!doRst) chk($sformatf("stall%0d", i), 64'(bus.OUT_stall[i]), 64'(st));
            acc = pend[i].valid && !st && !fl(pend[i]);
            if (doRst) mFull[i] = 0;
            else if (acc) begin
                mFull[i] = 1;
                mUop[i]  = pend[i];
            end else if (mFull[i] && (!cand[i] || win == i)) mFull[i] = 0;
            if (acc || fl(pend[i])) pend[i].valid = 1'b0;
        end
        if (doRst) mRr = 0;
        else if (win >= 0) mRr = (win + 1) % NP;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    // Monitor: pairs each presented FPU uop with the predicted one.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (monOn) begin
            have = (q.size() > 0) && (q[0].cyc == cyc);
            if (bus.OUT_uop.valid === 1'b1) begin
                if (!have) begin
                    total++;
                    bad++;
                    $display("FAIL spurious issue: got sqN %0h want none (cycle %0d)",
                             bus.OUT_uop.sqN, cyc);
                end else begin
                    e = q.pop_front();
                    chk("issue sqN", 64'(bus.OUT_uop.sqN), 64'(e.u.sqN));
                    chk("issue srcA", 64'(bus.OUT_uop.srcA), 64'(e.u.srcA));
                    chk("issue srcB", 64'(bus.OUT_uop.srcB), 64'(e.u.srcB));
                    chk("issue tag", 64'(bus.OUT_uop.tagDst), 64'(e.u.tagDst));
                    chk("grantPort", 64'(bus.OUT_grantPort), 64'(e.port));
                    chk("fpuEn", 64'(bus.OUT_fpuEn), 64'(bus.en && !fl(e.u)));
                end
            end else begin
                if (have) begin
                    e = q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing issue: got none want sqN %0h (cycle %0d)",
                             e.u.sqN, cyc);
                end
                chk("fpuEn idle", 64'(bus.OUT_fpuEn), 64'(0));
            end
        end
    end

    initial begin
        bus.en        = 1'b1;
        bus.IN_branch = '0;
        for (int i = 0; i < NP; i++) begin
            pend[i]  = '0;
            mFull[i] = 0;
        end
        @(posedge clk);
        #1;
        doReset();
        monOn = 1;
        chk("rst valid", 64'(bus.OUT_uop.valid), 64'(0));
        chk("rst port", 64'(bus.OUT_grantPort), 64'(0));
        chk("rst stall", 64'(bus.OUT_stall), 64'(0));
        chk("rst fpuEn", 64'(bus.OUT_fpuEn), 64'(0));

        // single request
        pend[0] = mk(5);
        step(0);
        step(0);
        chk("single valid", 64'(bus.OUT_uop.valid), 64'(1));
        chk("single sqN", 64'(bus.OUT_uop.sqN), 64'(5));
        chk("single port", 64'(bus.OUT_grantPort), 64'(0));
        step(0);

        // output register flushed in the following cycle
        doReset();
        pend[0] = mk(20);
        step(0);
        step(0);
        bus.IN_branch = '{sqN: SqN'(15), taken: 1'b1};
        #1;
        chk("outflush valid", 64'(bus.OUT_uop.valid), 64'(1));
        chk("outflush fpuEn", 64'(bus.OUT_fpuEn), 64'(0));
        step(0);
        bus.IN_branch = '0;

`ifndef FPU_ARB_ROUND_ROBIN_EN
        // age: older port1 first
        doReset();
        pend[0] = mk(9);
        pend[1] = mk(7);
        step(0);
        chk("age stall", 64'(bus.OUT_stall), 64'(2'b01));
        step(0);
        chk("age first", 64'(bus.OUT_uop.sqN), 64'(7));
        chk("age first port", 64'(bus.OUT_grantPort), 64'(1));
        step(0);
        chk("age second", 64'(bus.OUT_uop.sqN), 64'(9));
        chk("age second port", 64'(bus.OUT_grantPort), 64'(0));

        // wrap-around age
        doReset();
        pend[0] = mk('h02);
        pend[1] = mk('h7E);
        step(0);
        step(0);
        chk("wrap sqN", 64'(bus.OUT_uop.sqN), 64'('h7E));
        chk("wrap port", 64'(bus.OUT_grantPort), 64'(1));
        step(0);
        chk("wrap next", 64'(bus.OUT_uop.sqN), 64'('h02));

        // flush of a stalled slot while the older one issues
        doReset();
        pend[0] = mk(12);
        pend[1] = mk(10);
        step(0);
        bus.IN_branch = '{sqN: SqN'(11), taken: 1'b1};
        step(0);
        chk("flush sqN", 64'(bus.OUT_uop.sqN), 64'(10));
        chk("flush fpuEn", 64'(bus.OUT_fpuEn), 64'(1));
        chk("flush stall", 64'(bus.OUT_stall), 64'(0));
        bus.IN_branch = '0;
        step(0);
        chk("flush dropped", 64'(bus.OUT_uop.valid), 64'(0));
`else
        // round-robin: alternate grants, then reset mid-stream
        doReset();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NP; i++)
                if (!pend[i].valid) begin
                    pend[i] = mk(seq);
                    seq = seq + 1;
                end
            step(0);
            if (c >= 1)
                chk("rr port", 64'(bus.OUT_grantPort), 64'((c - 1) % 2));
        end
        doReset();
        chk("rr rst valid", 64'(bus.OUT_uop.valid), 64'(0));
        chk("rr rst stall", 64'(bus.OUT_stall), 64'(0));
`endif

        // randomized traffic
        doReset();
        for (int c = 0; c < 600; c++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0)
                bus.IN_branch = '{sqN: SqN'((seq - $urandom_range(0, 8)) & MASK),
                                  taken: 1'b1};
            else
                bus.IN_branch = '0;
            for (int i = 0; i < NP; i++)
                if (!pend[i].valid && $urandom_range(0, 9) < 6) begin
                    pend[i] = mk(seq);
                    seq = seq + $urandom_range(1, 3);
                end
            if ($urandom_range(0, 149) == 0) doReset();
            else step(0);
        end

        bus.en        = 1'b1;
        bus.IN_branch = '0;
        for (int c = 0; c < 6; c++) step(0);
        chk("queue drained", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
